// File: rtl/ssd_scan_ctl.sv
// Self-scanning, double-buffered multiplexer for common-anode seven-segment displays.
// Optional duty (brightness) control is compiled in when SSD_DIM_EN is defined.
module ssd_scan_ctl #(
  parameter int NUM_DIGITS = 4,
  parameter int SEG_W      = 8,
  parameter int DIV_CNT    = 50000,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
  input  logic                        load,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [3:0]                  brightness,
  output logic [SEG_W-1:0]            display,
  output logic [NUM_DIGITS-1:0]       display_c,
  output logic                        frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]      SLOT_LAST = CNT_W'(DIV_CNT - 1);
  localparam logic [CNT_W-1:0]      SLOT_PRE  = CNT_W'(DIV_CNT - 2);
  localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]                  slot_q, slot_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  pend_q, pend_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  act_q, act_d;
  logic [SEG_W-1:0]                  display_q, display_d;
  logic [NUM_DIGITS-1:0]             display_c_q, display_c_d;
  logic                              frame_done_q, frame_done_d;
  logic                              duty_ok_s;
  logic                              lit_s;

`ifdef SSD_DIM_EN
  localparam int PROD_W = CNT_W + 5;
  localparam logic [PROD_W-1:0] DIV_P = PROD_W'(DIV_CNT);
  logic [PROD_W-1:0] lhs_s;
  logic [PROD_W-1:0] rhs_s;

  // Duty window: lit while slot*16 < (brightness+1)*DIV_CNT, evaluated without overflow.
  always_comb begin
    lhs_s     = {1'b0, slot_q, 4'b0000};
    rhs_s     = {{(PROD_W-5){1'b0}}, ({1'b0, brightness} + 5'd1)} * DIV_P;
    duty_ok_s = (lhs_s < rhs_s);
  end
`else
  logic unused_brightness_s;
  assign unused_brightness_s = ^brightness;
  assign duty_ok_s           = 1'b1;
`endif

  // Next-state logic for scan position, buffers and registered outputs.
  always_comb begin
    slot_d       = slot_q;
    idx_d        = idx_q;
    pend_d       = pend_q;
    act_d        = act_q;
    display_d    = {SEG_W{1'b1}};
    display_c_d  = {NUM_DIGITS{1'b1}};
    frame_done_d = 1'b0;
    lit_s        = 1'b0;

    if (slot_q == SLOT_LAST) begin
      slot_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
      end
    end else begin
      slot_d = slot_q + {{(CNT_W-1){1'b0}}, 1'b1};
      idx_d  = idx_q;
    end

    // Pre-decode so the registered pulse coincides with the last slot of the frame.
    if ((slot_q == SLOT_PRE) && (idx_q == IDX_LAST)) begin
      frame_done_d = 1'b1;
    end else begin
      frame_done_d = 1'b0;
    end

    if (load) begin
      pend_d = seg_in;
    end else begin
      pend_d = pend_q;
    end

    // A load landing on the frame boundary bypasses pending straight into active.
    if (frame_done_q) begin
      if (load) begin
        act_d = seg_in;
      end else begin
        act_d = pend_q;
      end
    end else begin
      act_d = act_q;
    end

    lit_s = (slot_q != {CNT_W{1'b0}}) && digit_en[idx_q] && duty_ok_s;
    if (lit_s) begin
      display_d   = act_q[idx_q];
      display_c_d = ~(ONE_HOT0 << idx_q);
    end else begin
      display_d   = {SEG_W{1'b1}};
      display_c_d = {NUM_DIGITS{1'b1}};
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= {CNT_W{1'b0}};
      idx_q        <= {IDX_W{1'b0}};
      pend_q       <= {(NUM_DIGITS*SEG_W){1'b1}};
      act_q        <= {(NUM_DIGITS*SEG_W){1'b1}};
      display_q    <= {SEG_W{1'b1}};
      display_c_q  <= {NUM_DIGITS{1'b1}};
      frame_done_q <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      display_q    <= display_d;
      display_c_q  <= display_c_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign display    = display_q;
  assign display_c  = display_c_q;
  assign frame_done = frame_done_q;

endmodule
